// File: rtl/julia_frame_dispatcher_if.sv
// Core operand/result handshake and pixel stream between the frame dispatcher and its neighbours.
// master = dispatcher side, slave = core + frame-buffer writer side.
interface julia_frame_dispatcher_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_ITER_WIDTH = 16
);
    logic                             core_start_o;
    logic signed [DATA_WIDTH-1:0]     core_zx_o;
    logic signed [DATA_WIDTH-1:0]     core_zy_o;
    logic signed [DATA_WIDTH-1:0]     core_cx_o;
    logic signed [DATA_WIDTH-1:0]     core_cy_o;
    logic        [MAX_ITER_WIDTH-1:0] core_max_iter_o;
    logic        [MAX_ITER_WIDTH-1:0] core_iter_i;
    logic                             core_done_i;
    logic        [MAX_ITER_WIDTH-1:0] px_tdata_o;
    logic                             px_tvalid_o;
    logic                             px_tready_i;
    logic                             px_tuser_o;
    logic                             px_tlast_o;

    modport master (
        output core_start_o, core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o,
        input  core_iter_i, core_done_i,
        output px_tdata_o, px_tvalid_o, px_tuser_o, px_tlast_o,
        input  px_tready_i
    );

    modport slave (
        input  core_start_o, core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o,
        output core_iter_i, core_done_i,
        input  px_tdata_o, px_tvalid_o, px_tuser_o, px_tlast_o,
        output px_tready_i
    );
endinterface

// File: rtl/julia_frame_dispatcher.sv
// Walks a width x height pixel grid, issuing one core job per pixel and streaming escape counts out.
// Per pixel: 3 cycles + core latency; a low px_tready_i holds the pixel and stalls the next issue.
// Optional JULIA_DISP_ABORT_EN adds abort_i to end a frame early after the in-flight core job drains.
module julia_frame_dispatcher #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int DIM_BITS        = 11
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             frame_start_i,
    input  logic        [DIM_BITS-1:0]       width_i,
    input  logic        [DIM_BITS-1:0]       height_i,
    input  logic signed [DATA_WIDTH-1:0]     x0_i,
    input  logic signed [DATA_WIDTH-1:0]     y0_i,
    input  logic signed [DATA_WIDTH-1:0]     step_i,
    input  logic signed [DATA_WIDTH-1:0]     cx_i,
    input  logic signed [DATA_WIDTH-1:0]     cy_i,
    input  logic        [MAX_ITER_WIDTH-1:0] max_iter_i,
`ifdef JULIA_DISP_ABORT_EN
    input  logic                             abort_i,
`endif
    output logic                             busy_o,
    output logic                             frame_done_o,
    julia_frame_dispatcher_if.master         bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] OUT   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam logic [DIM_BITS-1:0] DIM_ONE = 1;

    logic [2:0]                      state;
    logic [DIM_BITS-1:0]             width_q, height_q, col, row;
    logic signed [DATA_WIDTH-1:0]    x0_q, step_q, cx_q, cy_q, zx, zy;
    logic [MAX_ITER_WIDTH-1:0]       max_iter_q, tdata_q;
    logic                            abort_req, abort_pend;
    logic                            last_col, last_row, handshake;

`ifdef JULIA_DISP_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    assign last_col  = (col == width_q - DIM_ONE);
    assign last_row  = (row == height_q - DIM_ONE);
    assign handshake = (state == OUT) && bus.px_tready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col        <= '0;
            row        <= '0;
            x0_q       <= '0;
            step_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            zx         <= '0;
            zy         <= '0;
            max_iter_q <= '0;
            tdata_q    <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        width_q    <= width_i;
                        height_q   <= height_i;
                        x0_q       <= x0_i;
                        step_q     <= step_i;
                        cx_q       <= cx_i;
                        cy_q       <= cy_i;
                        max_iter_q <= max_iter_i;
                        col        <= '0;
                        row        <= '0;
                        zx         <= x0_i;
                        zy         <= y0_i;
                        abort_pend <= 1'b0;
                        state      <= (width_i == '0 || height_i == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    // the core samples start on this edge, so an abort here still has a job to drain
                    if (abort_req) abort_pend <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.core_done_i) begin
                        if (abort_pend || abort_req) begin
                            abort_pend <= 1'b0;
                            state      <= FIN;
                        end else begin
                            tdata_q <= bus.core_iter_i;
                            state   <= OUT;
                        end
                    end else if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                end
                OUT: begin
                    if (abort_req) begin
                        state <= FIN;
                    end else if (handshake) begin
                        if (last_col && last_row) begin
                            state <= FIN;
                        end else if (last_col) begin
                            col   <= '0;
                            row   <= row + DIM_ONE;
                            zx    <= x0_q;
                            zy    <= zy - step_q;
                            state <= ISSUE;
                        end else begin
                            col   <= col + DIM_ONE;
                            zx    <= zx + step_q;
                            state <= ISSUE;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == FIN);

    assign bus.core_start_o    = (state == ISSUE);
    assign bus.core_zx_o       = zx;
    assign bus.core_zy_o       = zy;
    assign bus.core_cx_o       = cx_q;
    assign bus.core_cy_o       = cy_q;
    assign bus.core_max_iter_o = max_iter_q;

    assign bus.px_tdata_o  = tdata_q;
    assign bus.px_tvalid_o = (state == OUT);
    assign bus.px_tuser_o  = (state == OUT) && (col == '0) && (row == '0);
    assign bus.px_tlast_o  = (state == OUT) && last_col;
endmodule

// File: tb/tb_julia_frame_dispatcher.sv
// Directed bench: behavioural 4-cycle core, pixel/start logs, hand-computed 8.24 coordinates.
module tb_julia_frame_dispatcher;
    localparam logic [31:0] P1 = 32'h0100_0000;  //  1.0
    localparam logic [31:0] M1 = 32'hFF00_0000;  // -1.0
    localparam logic [31:0] PH = 32'h0080_0000;  //  0.5
    localparam logic [31:0] MH = 32'hFF80_0000;  // -0.5
    localparam logic [31:0] PQ = 32'h0040_0000;  //  0.25
    localparam logic [31:0] P2 = 32'h0200_0000;  //  2.0

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [10:0] width = '0, height = '0;
    logic [31:0] x0 = '0, y0 = '0, step = '0, cx = '0, cy = '0;
    logic [15:0] max_iter = '0;
    logic        busy, frame_done;
`ifdef JULIA_DISP_ABORT_EN
    logic        abort = 1'b0;
`endif

    julia_frame_dispatcher_if #(.DATA_WIDTH(32), .MAX_ITER_WIDTH(16)) bus ();

    julia_frame_dispatcher dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
        .width_i(width), .height_i(height),
        .x0_i(x0), .y0_i(y0), .step_i(step), .cx_i(cx), .cy_i(cy), .max_iter_i(max_iter),
`ifdef JULIA_DISP_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(busy), .frame_done_o(frame_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // behavioural core: done rises 4 cycles after start; result = 0x10 + job index
    int   start_cnt = 0;
    int   cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            bus.core_done_i <= 1'b0;
            cnt             <= 0;
        end else if (bus.core_start_o) begin
            bus.core_done_i <= 1'b0;
            bus.core_iter_i <= 16'h10 + start_cnt[15:0];
            start_cnt       <= start_cnt + 1;
            cnt             <= 4;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) bus.core_done_i <= 1'b1;
        end
    end

    logic [31:0] zx_log [0:63];
    logic [31:0] zy_log [0:63];
    logic [15:0] td_log [0:63];
    logic        tu_log [0:63];
    logic        tl_log [0:63];
    int ns = 0, np = 0, nd = 0;

    always @(negedge clk) begin
        if (bus.core_start_o && ns < 64) begin
            zx_log[ns] = bus.core_zx_o;
            zy_log[ns] = bus.core_zy_o;
            ns++;
        end
        if (bus.px_tvalid_o && bus.px_tready_i && np < 64) begin
            td_log[np] = bus.px_tdata_o;
            tu_log[np] = bus.px_tuser_o;
            tl_log[np] = bus.px_tlast_o;
            np++;
        end
        if (frame_done) nd++;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [10:0] w, input logic [10:0] h,
                               input logic [31:0] ix0, input logic [31:0] iy0, input logic [31:0] st);
        @(posedge clk); #1;
        width = w; height = h; x0 = ix0; y0 = iy0; step = st;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int c = 0;
        while (nd < target && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk("frame_done_count", nd, target);
        @(posedge clk); #1;
    endtask

    logic [31:0] ezx [4];
    logic [31:0] ezy [4];
    int sb, pb, db, viol;
    logic [15:0] s_td;
    logic s_tu, s_tl;
    logic [7:0] tuv, tlv;

    initial begin
        bus.px_tready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_core_start", bus.core_start_o, 0);
        chk("rst_tvalid", bus.px_tvalid_o, 0);
        chk("rst_tuser_tlast", {bus.px_tuser_o, bus.px_tlast_o}, 0);
        chk("rst_tdata", bus.px_tdata_o, 0);
        chk("rst_operands", {bus.core_zx_o, bus.core_cy_o}, 0);
        chk("rst_max_iter", bus.core_max_iter_o, 0);
        rst = 1'b0;

        // 2x2 frame
        sb = ns; pb = np; db = nd;
        cx = 32'h1234_5678; cy = MH; max_iter = 16'd500;
        start_frame(2, 2, M1, P1, PH);
        chk("t1_start_latency", bus.core_start_o, 1);
        chk("t1_max_iter", bus.core_max_iter_o, 500);
        chk("t1_cx", bus.core_cx_o, 32'h1234_5678);
        cx = '0; max_iter = '0;
        wait_frame(db + 1);
        chk("t1_starts", ns - sb, 4);
        chk("t1_pixels", np - pb, 4);
        ezx = '{M1, MH, M1, MH};
        ezy = '{P1, P1, PH, PH};
        tuv = '0; tlv = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_zx%0d", k), zx_log[sb+k], ezx[k]);
            chk($sformatf("t1_zy%0d", k), zy_log[sb+k], ezy[k]);
            chk($sformatf("t1_tdata%0d", k), td_log[pb+k], 16'h10 + 16'(sb + k));
            tuv[k] = tu_log[pb+k];
            tlv[k] = tl_log[pb+k];
        end
        chk("t1_tuser", tuv, 8'b0001);
        chk("t1_tlast", tlv, 8'b1010);
        chk("t1_idle", busy, 0);

        // 3x1 frame with a stalled pixel 1
        sb = ns; pb = np; db = nd;
        start_frame(3, 1, 32'h0, 32'h0, PH);
        for (int c = 0; c < 500; c++) begin
            if (np == pb + 1 && bus.px_tvalid_o) break;
            @(posedge clk); #1;
        end
        bus.px_tready_i = 1'b0;
        s_td = bus.px_tdata_o; s_tu = bus.px_tuser_o; s_tl = bus.px_tlast_o;
        viol = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.px_tdata_o !== s_td || bus.px_tuser_o !== s_tu ||
                bus.px_tlast_o !== s_tl || !bus.px_tvalid_o) viol++;
            if (bus.core_start_o) viol++;
        end
        chk("t2_stall_hold", viol, 0);
        chk("t2_stall_tdata", s_td, 16'h10 + 16'(sb + 1));
        chk("t2_stall_marks", {s_tu, s_tl}, 2'b00);
        bus.px_tready_i = 1'b1;
        wait_frame(db + 1);
        chk("t2_pixels", np - pb, 3);
        tuv = '0; tlv = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_tdata%0d", k), td_log[pb+k], 16'h10 + 16'(sb + k));
            tuv[k] = tu_log[pb+k];
            tlv[k] = tl_log[pb+k];
        end
        chk("t2_tuser", tuv, 8'b001);
        chk("t2_tlast", tlv, 8'b100);

        // empty frame
        sb = ns; db = nd;
        start_frame(0, 4, P1, P1, PH);
        chk("t3_no_start", bus.core_start_o, 0);
        chk("t3_done_pulse", frame_done, 1);
        chk("t3_busy_fin", busy, 1);
        @(posedge clk); #1;
        chk("t3_busy_after", busy, 0);
        chk("t3_done_after", frame_done, 0);
        chk("t3_starts", ns - sb, 0);
        chk("t3_done_count", nd - db, 1);

        // restart ignored mid-frame
        sb = ns; pb = np; db = nd;
        start_frame(2, 1, PQ, P1, PQ);
        repeat (2) @(posedge clk);
        #1;
        x0 = P2; width = 11'd5; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_frame(db + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_starts", ns - sb, 2);
        chk("t4_zx0", zx_log[sb], PQ);
        chk("t4_zx1", zx_log[sb+1], PH);
        chk("t4_pixels", np - pb, 2);
        chk("t4_done_count", nd - db, 1);
        chk("t4_idle", busy, 0);

        // reset while waiting on the core
        db = nd;
        start_frame(2, 2, M1, P1, PH);
        @(posedge clk); #1;
        chk("t5_in_wait", {busy, bus.core_start_o, bus.px_tvalid_o}, 3'b100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy", busy, 0);
        chk("t5_zx", bus.core_zx_o, 0);
        chk("t5_tdata", bus.px_tdata_o, 0);
        chk("t5_flags", {frame_done, bus.core_start_o, bus.px_tvalid_o}, 0);
        rst = 1'b0;
        chk("t5_no_done", nd - db, 0);
        sb = ns; pb = np; db = nd;
        start_frame(2, 1, M1, P1, PH);
        wait_frame(db + 1);
        chk("t5_zx0", zx_log[sb], M1);
        chk("t5_zx1", zx_log[sb+1], MH);
        chk("t5_pixels", np - pb, 2);
        chk("t5_tdata0", td_log[pb], 16'h10 + 16'(sb));
        chk("t5_tuser0", tu_log[pb], 1);

`ifdef JULIA_DISP_ABORT_EN
        sb = ns; pb = np; db = nd;
        start_frame(4, 1, 32'h0, 32'h0, PH);
        for (int c = 0; c < 500; c++) begin
            if (ns == sb + 3) break;
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_frame(db + 1);
        chk("ab_pixels", np - pb, 2);
        chk("ab_starts", ns - sb, 3);
        chk("ab_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
